// File: rtl/hwpe_tcdm_responder.sv
// Single-bank TCDM slave scratchpad for HWPE master ports: fixed response
// latency, byte-enabled writes and optional LFSR-driven grant stalls.
module hwpe_tcdm_responder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned LATENCY    = 1,
  parameter bit          STALL_EN   = 1'b0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    tcdm_req_i,
  output logic                    tcdm_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   tcdm_add_i,
  input  logic                    tcdm_wen_i,
  input  logic [DATA_WIDTH/8-1:0] tcdm_be_i,
  input  logic [DATA_WIDTH-1:0]   tcdm_data_i,
  output logic [DATA_WIDTH-1:0]   tcdm_r_data_o,
  output logic                    tcdm_r_valid_o,
  output logic [31:0]             nb_reads_o,
  output logic [31:0]             nb_writes_o,
  output logic                    err_o
);

  localparam int unsigned NB      = DATA_WIDTH / 8;
  localparam int unsigned OFF     = (NB > 1) ? $clog2(NB) : 0;
  localparam int unsigned IDX_W   = ADDR_WIDTH - OFF;
  localparam int unsigned MW_BITS = $clog2(MEM_WORDS);
  localparam logic [31:0] OOR_WORD = 32'hDEADBEEF;

  function automatic logic [DATA_WIDTH-1:0] oor_pattern();
    logic [DATA_WIDTH-1:0] p;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      p[i] = OOR_WORD[i % 32];
    end
    return p;
  endfunction

  localparam logic [DATA_WIDTH-1:0] OOR_DATA = oor_pattern();

  logic                  clr;
  logic                  stall;
  logic                  accept;
  logic                  out_of_range;
  logic [IDX_W-1:0]      word_idx;
  logic [MW_BITS-1:0]    mem_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [15:0]           lfsr;
  logic                  lfsr_fb;
  logic [LATENCY-1:0]    pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data [LATENCY];
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [31:0]           nb_reads;
  logic [31:0]           nb_writes;
  logic                  err;

  assign clr = rst_i | clear_i;

  // Byte-offset bits never select anything in a word-addressed bank.
  if (OFF > 0) begin : g_off
    logic unused_offset;
    assign unused_offset = ^tcdm_add_i[OFF-1:0];
  end

  assign word_idx = tcdm_add_i[ADDR_WIDTH-1:OFF];
  assign mem_idx  = word_idx[MW_BITS-1:0];

  if (IDX_W > MW_BITS) begin : g_oor
    assign out_of_range = |word_idx[IDX_W-1:MW_BITS];
  end else begin : g_no_oor
    assign out_of_range = 1'b0;
  end

  // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_ff @(posedge clk_i) begin
    if (clr) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr_fb, lfsr[15:1]};
    end
  end

  assign stall      = STALL_EN & (lfsr[1:0] == 2'b00);
  assign tcdm_gnt_o = tcdm_req_i & ~stall;
  assign accept     = tcdm_req_i & tcdm_gnt_o;

  // Memory is deliberately left out of reset so data survives rst/clear.
  always_ff @(posedge clk_i) begin
    if (accept && !tcdm_wen_i && !out_of_range) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (tcdm_be_i[b]) begin
          mem[mem_idx][b*8 +: 8] <= tcdm_data_i[b*8 +: 8];
        end
      end
    end
  end

  assign rd_word = out_of_range ? OOR_DATA : mem[mem_idx];

  always_ff @(posedge clk_i) begin
    if (clr) begin
      pipe_valid <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_data[0]  <= (accept && tcdm_wen_i) ? rd_word : '0;
      for (int i = 1; i < int'(LATENCY); i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign tcdm_r_valid_o = pipe_valid[LATENCY-1];
  assign tcdm_r_data_o  = pipe_data[LATENCY-1];

  always_ff @(posedge clk_i) begin
    if (clr) begin
      nb_reads  <= '0;
      nb_writes <= '0;
      err       <= 1'b0;
    end else begin
      if (accept && tcdm_wen_i) begin
        nb_reads <= nb_reads + 32'd1;
      end
      if (accept && !tcdm_wen_i) begin
        nb_writes <= nb_writes + 32'd1;
      end
      if (accept && out_of_range) begin
        err <= 1'b1;
      end
    end
  end

  assign nb_reads_o  = nb_reads;
  assign nb_writes_o = nb_writes;
  assign err_o       = err;

endmodule

// File: tb/tb_hwpe_tcdm_responder.sv
// Directed bench for hwpe_tcdm_responder: three instances cover LATENCY=1,
// LATENCY=3 and stalling grants against a reference LFSR.
module tb_hwpe_tcdm_responder;

  localparam int          DW   = 32;
  localparam int          AW   = 32;
  localparam int          MW   = 1024;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, clear;
  logic [AW-1:0] add;
  logic          wen;
  logic [3:0]    be;
  logic [DW-1:0] wdata;

  logic          req_1, gnt_1, rvalid_1, err_1;
  logic [DW-1:0] rdata_1;
  logic [31:0]   nbr_1, nbw_1;
  logic          req_3, gnt_3, rvalid_3, err_3;
  logic [DW-1:0] rdata_3;
  logic [31:0]   nbr_3, nbw_3;
  logic          req_s, gnt_s, rvalid_s, err_s;
  logic [DW-1:0] rdata_s_unused;
  logic [31:0]   nbr_s, nbw_s;

  int n_checks = 0;
  int n_errors = 0;
  int pulses_s = 0;
  logic [15:0] lfsr_model = SEED;

  hwpe_tcdm_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_WORDS(MW),
                        .LATENCY(1), .STALL_EN(1'b0), .LFSR_SEED(SEED)) dut_1 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .tcdm_req_i(req_1), .tcdm_gnt_o(gnt_1),
    .tcdm_add_i(add), .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(wdata),
    .tcdm_r_data_o(rdata_1), .tcdm_r_valid_o(rvalid_1), .nb_reads_o(nbr_1),
    .nb_writes_o(nbw_1), .err_o(err_1));

  hwpe_tcdm_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_WORDS(MW),
                        .LATENCY(3), .STALL_EN(1'b0), .LFSR_SEED(SEED)) dut_3 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .tcdm_req_i(req_3), .tcdm_gnt_o(gnt_3),
    .tcdm_add_i(add), .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(wdata),
    .tcdm_r_data_o(rdata_3), .tcdm_r_valid_o(rvalid_3), .nb_reads_o(nbr_3),
    .nb_writes_o(nbw_3), .err_o(err_3));

  hwpe_tcdm_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_WORDS(MW),
                        .LATENCY(1), .STALL_EN(1'b1), .LFSR_SEED(SEED)) dut_s (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .tcdm_req_i(req_s), .tcdm_gnt_o(gnt_s),
    .tcdm_add_i(add), .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(wdata),
    .tcdm_r_data_o(rdata_s_unused), .tcdm_r_valid_o(rvalid_s), .nb_reads_o(nbr_s),
    .nb_writes_o(nbw_s), .err_o(err_s));

  // Reference LFSR: Fibonacci taps 16,14,13,11, reloaded by rst or clear.
  always @(posedge clk) begin
    if (rst || clear) lfsr_model <= SEED;
    else lfsr_model <= {lfsr_model[0] ^ lfsr_model[2] ^ lfsr_model[3] ^ lfsr_model[5],
                        lfsr_model[15:1]};
  end

  always @(negedge clk) begin
    if (rvalid_s === 1'b1) pulses_s++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction on the LATENCY=1 instance: grant, response, then idle.
  task automatic applyStimulus(input string tag, input logic w, input logic [31:0] a,
                               input logic [3:0] b, input logic [31:0] d,
                               input logic [31:0] exp_rdata);
    add = a; wen = w; be = b; wdata = d; req_1 = 1'b1;
    #1 checkOutput({tag, "_gnt"}, 64'(gnt_1), 64'd1);
    @(posedge clk); #1 req_1 = 1'b0;
    checkOutput({tag, "_rvalid"}, 64'(rvalid_1), 64'd1);
    checkOutput({tag, "_rdata"}, 64'(rdata_1), 64'(exp_rdata));
    @(posedge clk); #1;
    checkOutput({tag, "_idle_rvalid"}, 64'(rvalid_1), 64'd0);
    checkOutput({tag, "_idle_rdata"}, 64'(rdata_1), 64'd0);
  endtask

  initial begin
    int   stall_mismatch, stall_seen, budget;
    logic granted, exp_gnt;

    rst = 1'b1; clear = 1'b0; req_1 = 1'b0; req_3 = 1'b0; req_s = 1'b0;
    add = '0; wen = 1'b1; be = 4'hF; wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    checkOutput("reset_rvalid", 64'(rvalid_1), 64'd0);
    checkOutput("reset_rdata", 64'(rdata_1), 64'd0);
    checkOutput("reset_nb_reads", 64'(nbr_1), 64'd0);
    checkOutput("reset_nb_writes", 64'(nbw_1), 64'd0);
    checkOutput("reset_err", 64'(err_1), 64'd0);

    applyStimulus("wr_cafe", 1'b0, 32'h10, 4'hF, 32'hCAFEF00D, 32'h0);
    applyStimulus("rd_cafe", 1'b1, 32'h10, 4'hF, 32'h0, 32'hCAFEF00D);
    checkOutput("cnt_writes_1", 64'(nbw_1), 64'd1);
    checkOutput("cnt_reads_1", 64'(nbr_1), 64'd1);

    applyStimulus("wr_pre", 1'b0, 32'h20, 4'hF, 32'h11223344, 32'h0);
    applyStimulus("wr_be5", 1'b0, 32'h20, 4'b0101, 32'hAABBCCDD, 32'h0);
    applyStimulus("rd_be5", 1'b1, 32'h20, 4'hF, 32'h0, 32'h11BB33DD);
    applyStimulus("wr_be0", 1'b0, 32'h20, 4'h0, 32'hFFFFFFFF, 32'h0);
    applyStimulus("rd_be0", 1'b1, 32'h20, 4'hF, 32'h0, 32'h11BB33DD);
    applyStimulus("rd_offset", 1'b1, 32'h13, 4'hF, 32'h0, 32'hCAFEF00D);
    checkOutput("err_before_oor", 64'(err_1), 64'd0);

    applyStimulus("wr_zero", 1'b0, 32'h0, 4'hF, 32'h55AA55AA, 32'h0);
    applyStimulus("rd_oor", 1'b1, 32'(MW * 4), 4'hF, 32'h0, 32'hDEADBEEF);
    checkOutput("err_after_oor", 64'(err_1), 64'd1);
    applyStimulus("wr_oor", 1'b0, 32'(MW * 4), 4'hF, 32'h12345678, 32'h0);
    applyStimulus("rd_zero", 1'b1, 32'h0, 4'hF, 32'h0, 32'h55AA55AA);
    checkOutput("err_sticky", 64'(err_1), 64'd1);
    checkOutput("cnt_writes_6", 64'(nbw_1), 64'd6);
    checkOutput("cnt_reads_6", 64'(nbr_1), 64'd6);

    clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    checkOutput("clear_err", 64'(err_1), 64'd0);
    checkOutput("clear_nb_reads", 64'(nbr_1), 64'd0);
    checkOutput("clear_nb_writes", 64'(nbw_1), 64'd0);
    applyStimulus("rd_after_clear", 1'b1, 32'h10, 4'hF, 32'h0, 32'hCAFEF00D);
    checkOutput("cnt_reads_after_clear", 64'(nbr_1), 64'd1);

    // LATENCY=3: preload four words, then four back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      add = 32'(i * 4); wen = 1'b0; be = 4'hF; wdata = 32'(i + 1); req_3 = 1'b1;
      #1 checkOutput("l3_wr_gnt", 64'(gnt_3), 64'd1);
      @(posedge clk); #1;
    end
    req_3 = 1'b0;
    repeat (4) @(posedge clk);
    #1 checkOutput("l3_nb_writes", 64'(nbw_3), 64'd4);

    for (int c = 0; c < 9; c++) begin
      req_3 = (c < 4); add = 32'(c * 4); wen = 1'b1;
      #1;
      checkOutput($sformatf("l3_rvalid_c%0d", c), 64'(rvalid_3), 64'((c >= 3 && c <= 6) ? 1 : 0));
      checkOutput($sformatf("l3_rdata_c%0d", c), 64'(rdata_3), 64'((c >= 3 && c <= 6) ? c - 2 : 0));
      @(posedge clk); #1;
    end
    req_3 = 1'b0;
    checkOutput("l3_nb_reads", 64'(nbr_3), 64'd4);

    // Reset while two reads are in flight drops both responses.
    for (int c = 0; c < 9; c++) begin
      req_3 = (c < 2); add = 32'(c * 4); wen = 1'b1;
      rst = (c == 2);
      #1;
      if (c >= 2) checkOutput($sformatf("rst_drop_rvalid_c%0d", c), 64'(rvalid_3), 64'd0);
      @(posedge clk); #1;
    end
    req_3 = 1'b0; rst = 1'b0;
    checkOutput("rst_nb_reads", 64'(nbr_3), 64'd0);
    checkOutput("rst_nb_writes", 64'(nbw_3), 64'd0);

    for (int c = 0; c < 6; c++) begin
      req_3 = (c == 0); add = 32'h8; wen = 1'b1;
      #1;
      checkOutput($sformatf("rst_keep_rvalid_c%0d", c), 64'(rvalid_3), 64'((c == 3) ? 1 : 0));
      checkOutput($sformatf("rst_keep_rdata_c%0d", c), 64'(rdata_3), 64'((c == 3) ? 3 : 0));
      @(posedge clk); #1;
    end
    req_3 = 1'b0;
    checkOutput("l3_err", 64'(err_3), 64'd0);

    // Stalling instance: 200 single reads, grant compared every cycle.
    stall_mismatch = 0; stall_seen = 0; budget = 4000; pulses_s = 0;
    for (int n = 0; n < 200; n++) begin
      granted = 1'b0;
      while (!granted && budget > 0) begin
        add = 32'(n * 4); wen = 1'b1; be = 4'hF; req_s = 1'b1;
        #1;
        exp_gnt = (lfsr_model[1:0] != 2'b00);
        if (gnt_s !== exp_gnt) stall_mismatch++;
        if (gnt_s !== 1'b1) stall_seen++;
        granted = (gnt_s === 1'b1);
        budget--;
        @(posedge clk); #1;
      end
    end
    req_s = 1'b0;
    checkOutput("stall_budget_left", 64'(budget > 0), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stall_gnt_mismatch_cycles", 64'(stall_mismatch), 64'd0);
    checkOutput("stall_some_stalls", 64'(stall_seen > 0), 64'd1);
    checkOutput("stall_rvalid_pulses", 64'(pulses_s), 64'd200);
    checkOutput("stall_nb_reads", 64'(nbr_s), 64'd200);
    checkOutput("stall_nb_writes", 64'(nbw_s), 64'd0);
    checkOutput("stall_err", 64'(err_s), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
